// File: rtl/uc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uc_sequencer_pkg
//  Description : Shared definitions for the instruction sequencer: field
//                widths, opcode constants and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uc_sequencer_pkg;

    // Instruction field widths
    localparam int c_DATA_W = 8;
    localparam int c_OP_W   = 4;
    localparam int c_ARG_W  = 4;

    // Opcodes (instr[7:4]); 9..E are illegal
    localparam logic [c_OP_W-1:0] c_OP_NOP = 4'h0;
    localparam logic [c_OP_W-1:0] c_OP_LDA = 4'h1;
    localparam logic [c_OP_W-1:0] c_OP_LDI = 4'h2;
    localparam logic [c_OP_W-1:0] c_OP_ADD = 4'h3;
    localparam logic [c_OP_W-1:0] c_OP_SUB = 4'h4;
    localparam logic [c_OP_W-1:0] c_OP_JMP = 4'h5;
    localparam logic [c_OP_W-1:0] c_OP_JZ  = 4'h6;
    localparam logic [c_OP_W-1:0] c_OP_IN  = 4'h7;
    localparam logic [c_OP_W-1:0] c_OP_OUT = 4'h8;
    localparam logic [c_OP_W-1:0] c_OP_HLT = 4'hF;

    // Sequencer state encoding
    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_FETCH    = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_DECODE   = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_EXEC     = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_OPER     = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_IMM      = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_IN  = 3'd5;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_OUT = 3'd6;
    localparam logic [c_ST_W-1:0] c_ST_HALT     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/uc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : uc_decode
//  Description : Combinational opcode classifier.
//                i_opcode     - 4-bit opcode
//                o_single     - single-cycle execute class (NOP..JZ)
//                o_two_byte   - needs an immediate byte (LDI)
//                o_io         - external I/O handshake (IN, OUT)
//                o_halt       - HLT
//                o_illegal    - opcodes 9..E
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_decode
    import uc_sequencer_pkg::*;
(
    input  logic [c_OP_W-1:0] i_opcode,
    output logic              o_single,
    output logic              o_two_byte,
    output logic              o_io,
    output logic              o_halt,
    output logic              o_illegal
);

    always_comb begin
        o_single   = 1'b0;
        o_two_byte = 1'b0;
        o_io       = 1'b0;
        o_halt     = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            c_OP_NOP, c_OP_LDA, c_OP_ADD,
            c_OP_SUB, c_OP_JMP, c_OP_JZ:  o_single   = 1'b1;
            c_OP_LDI:                     o_two_byte = 1'b1;
            c_OP_IN, c_OP_OUT:            o_io       = 1'b1;
            c_OP_HLT:                     o_halt     = 1'b1;
            default:                      o_illegal  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uc_sequencer
//  Description : Fetch/decode/execute sequencer for the 8-bit processor.
//                Produces the accontrol strobes (jump, jumpC, sin, sub, InA,
//                twone), program-memory strobes (mem_rd, pc_inc, ir_load)
//                and the input/output handshakes.
//  Ports       : clock, reset (sync, active-high), instr[7:0], in_valid,
//                out_ready -> mem_rd, pc_inc, ir_load, jump, jumpC, sin, sub,
//                InA, twone, in_ready, out_valid, halted, illegal
//  Build macro : UC_ILLEGAL_TRAP_EN - illegal opcodes 9..E halt the sequencer
//                and raise 'illegal'; otherwise they behave as NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module uc_sequencer
    import uc_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [c_DATA_W-1:0] instr,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic                mem_rd,
    output logic                pc_inc,
    output logic                ir_load,
    output logic                jump,
    output logic                jumpC,
    output logic                sin,
    output logic                sub,
    output logic                InA,
    output logic                twone,
    output logic                in_ready,
    output logic                out_valid,
    output logic                halted,
    output logic                illegal
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next;
    logic [c_OP_W-1:0] r_op;
    logic [c_OP_W-1:0] w_opcode;
    logic              w_single;
    logic              w_two_byte;
    logic              w_io;
    logic              w_halt;
    logic              w_illegal;

    // During DECODE the IR is still being loaded, so classify straight from
    // the memory bus; afterwards use the captured opcode.
    assign w_opcode = (r_state == c_ST_DECODE) ? instr[c_DATA_W-1:c_ARG_W] : r_op;

    uc_decode u_decode (
        .i_opcode   (w_opcode),
        .o_single   (w_single),
        .o_two_byte (w_two_byte),
        .o_io       (w_io),
        .o_halt     (w_halt),
        .o_illegal  (w_illegal)
    );

    // ------------------------------------------------------------------
    // State and IR registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_FETCH;
            r_op    <= c_OP_NOP;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_DECODE) begin
                r_op <= instr[c_DATA_W-1:c_ARG_W];
            end
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap flag; only reset clears it, matching the HALT exit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if ((r_state == c_ST_DECODE) && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, instr[c_ARG_W-1:0]};
`else
    logic w_unused;
    assign w_unused = &{1'b0, instr[c_ARG_W-1:0], w_illegal};
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_FETCH:  w_next = c_ST_DECODE;
            c_ST_DECODE: begin
                if (w_two_byte) begin
                    w_next = c_ST_OPER;
                end else if (w_halt) begin
                    w_next = c_ST_HALT;
                end else if (w_single || w_io) begin
                    w_next = c_ST_EXEC;
                end else begin
`ifdef UC_ILLEGAL_TRAP_EN
                    w_next = c_ST_HALT;
`else
                    w_next = c_ST_EXEC;
`endif
                end
            end
            c_ST_EXEC: begin
                if (w_io) begin
                    w_next = (r_op == c_OP_IN) ? c_ST_WAIT_IN : c_ST_WAIT_OUT;
                end else begin
                    w_next = c_ST_FETCH;
                end
            end
            c_ST_OPER:     w_next = c_ST_IMM;
            c_ST_IMM:      w_next = c_ST_FETCH;
            c_ST_WAIT_IN:  w_next = in_valid  ? c_ST_FETCH : c_ST_WAIT_IN;
            c_ST_WAIT_OUT: w_next = out_ready ? c_ST_FETCH : c_ST_WAIT_OUT;
            c_ST_HALT:     w_next = c_ST_HALT;
            default:       w_next = c_ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is forced low while reset is asserted so an
    // abandoned instruction cannot emit a strobe in the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd    = 1'b0;
        pc_inc    = 1'b0;
        ir_load   = 1'b0;
        jump      = 1'b0;
        jumpC     = 1'b0;
        sin       = 1'b0;
        sub       = 1'b0;
        InA       = 1'b0;
        twone     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (r_state)
                c_ST_FETCH, c_ST_OPER: begin
                    mem_rd = 1'b1;
                    pc_inc = 1'b1;
                end
                c_ST_DECODE: ir_load = 1'b1;
                c_ST_EXEC: begin
                    case (r_op)
                        c_OP_ADD: sin = 1'b1;
                        c_OP_SUB: begin
                            sin = 1'b1;
                            sub = 1'b1;
                        end
                        c_OP_JMP: jump  = 1'b1;
                        c_OP_JZ:  jumpC = 1'b1;
                        default:  ;
                    endcase
                end
                c_ST_IMM: twone = 1'b1;
                c_ST_WAIT_IN: begin
                    in_ready = in_valid;
                    InA      = in_valid;
                end
                c_ST_WAIT_OUT: out_valid = 1'b1;
                c_ST_HALT: begin
                    halted = 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
                    illegal = r_illegal;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uc_sequencer
//  Description : Directed self-checking bench for uc_sequencer. Every cycle
//                the full output vector is compared against a hand-written
//                expected pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       in_valid;
    logic       out_ready;
    logic mem_rd, pc_inc, ir_load, jump, jumpC, sin, sub, InA, twone;
    logic in_ready, out_valid, halted, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    uc_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .instr     (instr),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .mem_rd    (mem_rd),
        .pc_inc    (pc_inc),
        .ir_load   (ir_load),
        .jump      (jump),
        .jumpC     (jumpC),
        .sin       (sin),
        .sub       (sub),
        .InA       (InA),
        .twone     (twone),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Output vector, MSB first
    logic [12:0] w_obs;
    assign w_obs = {mem_rd, pc_inc, ir_load, jump, jumpC, sin, sub,
                    InA, twone, in_ready, out_valid, halted, illegal};

    localparam logic [12:0] c_NONE = 13'b0;
    localparam logic [12:0] c_FET  = 13'b1100000000000;
    localparam logic [12:0] c_DEC  = 13'b0010000000000;
    localparam logic [12:0] c_JMP  = 13'b0001000000000;
    localparam logic [12:0] c_JZ   = 13'b0000100000000;
    localparam logic [12:0] c_ADD  = 13'b0000010000000;
    localparam logic [12:0] c_SUB  = 13'b0000011000000;
    localparam logic [12:0] c_INA  = 13'b0000000101000;
    localparam logic [12:0] c_IMM  = 13'b0000000010000;
    localparam logic [12:0] c_OV   = 13'b0000000000100;
    localparam logic [12:0] c_HLT  = 13'b0000000000010;
    localparam logic [12:0] c_ILL  = 13'b0000000000011;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with inputs already set; checks mid-cycle, then
    // advances to the next posedge+1.
    task automatic cyc(input string tag, input logic [12:0] exp);
        #2;
        check(tag, w_obs, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [7:0] op);
        instr = op;
        cyc({tag, "_fetch"}, c_FET);
        cyc({tag, "_decode"}, c_DEC);
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 8'h30;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        cyc("reset0", c_NONE);
        cyc("reset1", c_NONE);
        reset = 1'b0;

        // ADD, SUB
        fetch_decode("add", 8'h30);
        cyc("add_exec", c_ADD);
        fetch_decode("sub", 8'h40);
        cyc("sub_exec", c_SUB);

        // LDI: immediate fetch then twone
        fetch_decode("ldi", 8'h25);
        instr = 8'h7F;
        cyc("ldi_oper", c_FET);
        cyc("ldi_imm", c_IMM);

        // JMP then JZ
        fetch_decode("jmp", 8'h5A);
        cyc("jmp_exec", c_JMP);
        fetch_decode("jz", 8'h63);
        cyc("jz_exec", c_JZ);

        // NOP, LDA with stray handshakes that must be ignored
        in_valid  = 1'b1;
        out_ready = 1'b1;
        fetch_decode("nop", 8'h00);
        cyc("nop_exec", c_NONE);
        fetch_decode("lda", 8'h1C);
        cyc("lda_exec", c_NONE);
        out_ready = 1'b0;

        // IN with input already available on entry to WAIT_IN
        fetch_decode("in_fast", 8'h70);
        cyc("in_fast_exec", c_NONE);
        cyc("in_fast_wait", c_INA);

        // IN with input arriving after five idle cycles
        in_valid = 1'b0;
        fetch_decode("in_slow", 8'h70);
        cyc("in_slow_exec", c_NONE);
        for (int i = 0; i < 5; i++) cyc("in_slow_idle", c_NONE);
        in_valid = 1'b1;
        cyc("in_slow_acc", c_INA);
        in_valid = 1'b0;

        // OUT with sink stalling three cycles
        fetch_decode("out", 8'h80);
        cyc("out_exec", c_NONE);
        for (int i = 0; i < 3; i++) cyc("out_hold", c_OV);
        out_ready = 1'b1;
        cyc("out_acc", c_OV);
        out_ready = 1'b0;

        // OUT abandoned by reset while waiting
        fetch_decode("out_rst", 8'h80);
        cyc("out_rst_exec", c_NONE);
        cyc("out_rst_wait", c_OV);
        reset = 1'b1;
        cyc("out_rst_reset", c_NONE);
        reset = 1'b0;

        // Illegal opcode
        fetch_decode("ill", 8'hB0);
`ifdef UC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc("ill_trap", c_ILL);
        reset = 1'b1;
        cyc("ill_reset", c_NONE);
        reset = 1'b0;
`else
        cyc("ill_exec", c_NONE);
`endif

        // HLT holds through stray inputs until reset
        fetch_decode("hlt", 8'hF0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc("hlt_hold", c_HLT);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        cyc("hlt_reset", c_NONE);
        reset = 1'b0;
        fetch_decode("post", 8'h30);
        cyc("post_exec", c_ADD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
